// File: rtl/nco_pkg.sv
// Shared definitions for the quadrature NCO: default widths, quadrant
// encoding, and the quarter-wave sine table generator.
package nco_pkg;

    localparam int PHASE_W_DEF = 24;
    localparam int ADDR_W_DEF  = 10;
    localparam int DATA_W_DEF  = 12;

    localparam int  SIN_TERMS = 12;
    localparam real PI        = 3.14159265358979323846;

    // Top two address bits select the quadrant of the full wave.
    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

    // Odd quadrants read the quarter table backwards.
    function automatic logic quad_mirror(input quad_e q);
        logic m;
        case (q)
            QUAD_1, QUAD_3: m = 1'b1;
            QUAD_0, QUAD_2: m = 1'b0;
            default:        m = 1'b0;
        endcase
        return m;
    endfunction

    // The second half-wave is the negated first half-wave.
    function automatic logic quad_negate(input quad_e q);
        logic n;
        case (q)
            QUAD_2, QUAD_3: n = 1'b1;
            QUAD_0, QUAD_1: n = 1'b0;
            default:        n = 1'b0;
        endcase
        return n;
    endfunction

    // round((2^(data_w-1)-1) * sin(2*pi*(k+0.5)/2^addr_w)); Taylor series so the
    // table can be built at elaboration without math library calls.
    function automatic int quarter_rom_val(input int k,
                                           input int addr_w = ADDR_W_DEF,
                                           input int data_w = DATA_W_DEF);
        real amp;
        real x;
        real x2;
        real term;
        real acc;
        amp  = real'((1 << (data_w - 1)) - 1);
        x    = 2.0 * PI * (real'(k) + 0.5) / real'(1 << addr_w);
        x2   = x * x;
        term = x;
        acc  = x;
        for (int n = 1; n <= SIN_TERMS; n++) begin
            term = -term * x2 / real'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return $rtoi(amp * acc + 0.5);
    endfunction

endpackage

// File: rtl/nco_iq_if.sv
// Control/sample bus of the quadrature NCO: tuning inputs from the register
// block, phase address and I/Q samples towards the mixer.
interface nco_iq_if
    import nco_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    logic                     EN;
    logic [PHASE_W-1:0]       ftw;
    logic [PHASE_W-1:0]       pow;
    logic                     load;
    logic                     sync;
    logic [ADDR_W-1:0]        address;
    logic signed [DATA_W-1:0] sine;
    logic signed [DATA_W-1:0] cosine;
    logic                     out_valid;
    logic                     wrap;

    modport master (
        output EN, ftw, pow, load, sync,
        input  address, sine, cosine, out_valid, wrap
    );

    modport slave (
        input  EN, ftw, pow, load, sync,
        output address, sine, cosine, out_valid, wrap
    );
endinterface

// File: rtl/nco_qrom.sv
// Synchronous-read quarter-wave sine ROM; contents generated at elaboration
// from nco_pkg::quarter_rom_val.
module nco_qrom
    import nco_pkg::*;
#(
    parameter int AW = ADDR_W_DEF - 2,
    parameter int DW = DATA_W_DEF - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] rom_s [DEPTH];
    logic [DW-1:0] data_r;

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [DW-1:0] VAL = DW'(quarter_rom_val(k, AW + 2, DW + 1));
        assign rom_s[k] = VAL;
    end

    // Registered table read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= {DW{1'b0}};
        end else begin
            data_r <= rom_s[addr];
        end
    end

    assign data = data_r;

endmodule

// File: rtl/nco_iq.sv
// Quadrature NCO: phase accumulator with run-time tuning/offset words feeding a
// three-stage quadrant-folded quarter-wave lookup for sine and cosine.
module nco_iq
    import nco_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    nco_iq_if.slave  bus
);
    localparam int QW = ADDR_W - 2;
    localparam int MW = DATA_W - 1;
    localparam logic [ADDR_W-1:0] COS_OFFSET = {2'b01, {QW{1'b0}}};

    logic [PHASE_W-1:0] ftw_r;
    logic [PHASE_W-1:0] pow_r;
    logic [PHASE_W-1:0] acc_r;
    logic [PHASE_W:0]   sum_s;
    logic [PHASE_W-1:0] phase_s;
    logic               wrap_r;

    logic [ADDR_W-1:0]  address_r;
    logic [ADDR_W-1:0]  cos_addr_s;
    quad_e              sin_quad_s;
    quad_e              cos_quad_s;
    logic [QW-1:0]      sin_idx_s;
    logic [QW-1:0]      cos_idx_s;

    logic [MW-1:0]      sin_mag_s;
    logic [MW-1:0]      cos_mag_s;
    logic               sin_neg_r;
    logic               cos_neg_r;

    logic [DATA_W-1:0]  sin_val_s;
    logic [DATA_W-1:0]  cos_val_s;
    logic [DATA_W-1:0]  sine_r;
    logic [DATA_W-1:0]  cosine_r;

    logic [2:0]         en_dly_r;
    logic               valid_r;

    assign sum_s   = {1'b0, acc_r} + {1'b0, ftw_r};
    assign phase_s = acc_r + pow_r;

    // Fractional phase bits below the table resolution are simply dropped.
    if (ADDR_W < PHASE_W) begin : g_phase_lo
        logic unused_phase_lo_s;
        assign unused_phase_lo_s = ^phase_s[PHASE_W-ADDR_W-1:0];
    end

    // Active tuning/offset words; the accumulator at a load edge still sees the old ftw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ftw_r <= {PHASE_W{1'b0}};
            pow_r <= {PHASE_W{1'b0}};
        end else if (bus.load) begin
            ftw_r <= bus.ftw;
            pow_r <= bus.pow;
        end else begin
            ftw_r <= ftw_r;
            pow_r <= pow_r;
        end
    end

    // Phase accumulator with sync priority and registered overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= {PHASE_W{1'b0}};
            wrap_r <= 1'b0;
        end else if (bus.sync) begin
            acc_r  <= {PHASE_W{1'b0}};
            wrap_r <= 1'b0;
        end else if (bus.EN) begin
            acc_r  <= sum_s[PHASE_W-1:0];
            wrap_r <= sum_s[PHASE_W];
        end else begin
            acc_r  <= acc_r;
            wrap_r <= 1'b0;
        end
    end

    // Stage 1: full-wave phase address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address_r <= {ADDR_W{1'b0}};
        end else begin
            address_r <= phase_s[PHASE_W-1 -: ADDR_W];
        end
    end

    assign cos_addr_s = address_r + COS_OFFSET;
    assign sin_quad_s = quad_e'(address_r[ADDR_W-1 -: 2]);
    assign cos_quad_s = quad_e'(cos_addr_s[ADDR_W-1 -: 2]);

    // Fold each full-wave address onto the quarter table.
    always_comb begin
        sin_idx_s = address_r[QW-1:0];
        cos_idx_s = cos_addr_s[QW-1:0];
        if (quad_mirror(sin_quad_s)) begin
            sin_idx_s = ~address_r[QW-1:0];
        end else begin
            sin_idx_s = address_r[QW-1:0];
        end
        if (quad_mirror(cos_quad_s)) begin
            cos_idx_s = ~cos_addr_s[QW-1:0];
        end else begin
            cos_idx_s = cos_addr_s[QW-1:0];
        end
    end

    nco_qrom #(.AW(QW), .DW(MW)) u_sin_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (sin_idx_s),
        .data  (sin_mag_s)
    );

    nco_qrom #(.AW(QW), .DW(MW)) u_cos_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (cos_idx_s),
        .data  (cos_mag_s)
    );

    // Stage 2: sign flags travel alongside the ROM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin_neg_r <= 1'b0;
            cos_neg_r <= 1'b0;
        end else begin
            sin_neg_r <= quad_negate(sin_quad_s);
            cos_neg_r <= quad_negate(cos_quad_s);
        end
    end

    // Apply sign; magnitude never exceeds 2^(DATA_W-1)-1 so negation cannot overflow.
    always_comb begin
        sin_val_s = {1'b0, sin_mag_s};
        cos_val_s = {1'b0, cos_mag_s};
        if (sin_neg_r) begin
            sin_val_s = {DATA_W{1'b0}} - {1'b0, sin_mag_s};
        end else begin
            sin_val_s = {1'b0, sin_mag_s};
        end
        if (cos_neg_r) begin
            cos_val_s = {DATA_W{1'b0}} - {1'b0, cos_mag_s};
        end else begin
            cos_val_s = {1'b0, cos_mag_s};
        end
    end

    // Stage 3: output samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sine_r   <= {DATA_W{1'b0}};
            cosine_r <= {DATA_W{1'b0}};
        end else begin
            sine_r   <= sin_val_s;
            cosine_r <= cos_val_s;
        end
    end

    // Valid follows EN through the same three stages; sync alone never makes one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_dly_r <= 3'b000;
            valid_r  <= 1'b0;
        end else begin
            en_dly_r <= {en_dly_r[1:0], bus.EN};
            valid_r  <= en_dly_r[2];
        end
    end

    assign bus.address   = address_r;
    assign bus.sine      = sine_r;
    assign bus.cosine    = cosine_r;
    assign bus.out_valid = valid_r;
    assign bus.wrap      = wrap_r;

endmodule
